// File: rtl/paddle_pot_scheduler.sv
// VIC pot-line RC emulation: multiplexes one paddle pair onto POTX/POTY and
// sequences latch, discharge, timed charge and compare for each scan.
module paddle_pot_scheduler #(
   parameter int unsigned DISCHARGE_CYC = 256,
   parameter int unsigned SETTLE_SCANS  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ce,
   input  logic            scan_start,
   input  logic            pair_sel,
   input  logic [3:0][7:0] pd_in,
   input  logic [3:0]      pd_valid,
   output logic            pot_x,
   output logic            pot_y,
   output logic [7:0]      pot_val_x,
   output logic [7:0]      pot_val_y,
   output logic            busy,
   output logic            settling
);

   localparam int unsigned CW = (DISCHARGE_CYC > 256) ? $clog2(DISCHARGE_CYC) : 8;
   localparam int unsigned SW = (SETTLE_SCANS > 0) ? $clog2(SETTLE_SCANS + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISCHARGE,
      S_CHARGE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_tx;
   logic [7:0]      r_ty;
   logic            r_pair_q;
   logic [SW-1:0]   r_settle_cnt;

   logic [1:0]      w_ix_x;
   logic [1:0]      w_ix_y;
   logic [7:0]      w_tx_sel;
   logic [7:0]      w_ty_sel;
   logic            w_start;
   logic            w_dis_done;
   logic            w_chg_tick;
   logic            w_chg_done;
   logic            w_hit_x;
   logic            w_hit_y;
   logic            w_pair_chg;
   logic            w_upd_ok;

   assign w_ix_x     = {r_pair_q, 1'b0};
   assign w_ix_y     = {r_pair_q, 1'b1};
   assign w_tx_sel   = pd_valid[w_ix_x] ? pd_in[w_ix_x] : 8'hFF;
   assign w_ty_sel   = pd_valid[w_ix_y] ? pd_in[w_ix_y] : 8'hFF;

   assign w_start    = ce && (r_state == S_IDLE) && scan_start;
   assign w_dis_done = ce && (r_state == S_DISCHARGE) && (r_cnt == CW'(DISCHARGE_CYC - 1));
   assign w_chg_tick = ce && (r_state == S_CHARGE);
   // Counter is cleared on CHARGE entry, so only its low byte is live here.
   assign w_chg_done = w_chg_tick && (r_cnt[7:0] == 8'hFF);
   assign w_hit_x    = w_chg_tick && (r_cnt[7:0] == r_tx);
   assign w_hit_y    = w_chg_tick && (r_cnt[7:0] == r_ty);
   assign w_pair_chg = (pair_sel != r_pair_q);
   assign w_upd_ok   = (r_settle_cnt == '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (ce) begin
         case (r_state)
            S_IDLE:      if (scan_start) w_state_nxt = S_DISCHARGE;
            S_DISCHARGE: if (w_dis_done) w_state_nxt = S_CHARGE;
            S_CHARGE:    if (w_chg_done) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      busy     = (r_state != S_IDLE);
      settling = (r_settle_cnt != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (ce) begin
         case (r_state)
            S_IDLE:      if (scan_start) r_cnt <= '0;
            S_DISCHARGE: r_cnt <= w_dis_done ? '0 : r_cnt + CW'(1);
            S_CHARGE:    r_cnt <= w_chg_done ? '0 : r_cnt + CW'(1);
            default:     r_cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx <= 8'hFF;
         r_ty <= 8'hFF;
      end else if (w_start) begin
         r_tx <= w_tx_sel;
         r_ty <= w_ty_sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pot_x     <= 1'b0;
         pot_y     <= 1'b0;
         pot_val_x <= 8'hFF;
         pot_val_y <= 8'hFF;
      end else begin
         if (w_start) begin
            pot_x <= 1'b0;
            pot_y <= 1'b0;
         end else begin
            if (w_hit_x) pot_x <= 1'b1;
            if (w_hit_y) pot_y <= 1'b1;
         end
         if (w_hit_x && w_upd_ok) pot_val_x <= r_cnt[7:0];
         if (w_hit_y && w_upd_ok) pot_val_y <= r_cnt[7:0];
      end
   end

   // A pair change reloads the settle count even mid-scan, discarding that scan too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pair_q     <= pair_sel;
         r_settle_cnt <= '0;
      end else if (w_pair_chg) begin
         r_pair_q     <= pair_sel;
         r_settle_cnt <= SW'(SETTLE_SCANS);
      end else if (w_chg_done && !w_upd_ok) begin
         r_settle_cnt <= r_settle_cnt - SW'(1);
      end
   end

endmodule

// File: tb/tb_paddle_pot_scheduler.sv
// Directed bench for paddle_pot_scheduler: scan timing, invalid paddles,
// pair-switch settling, ignored mid-scan inputs, async reset and slow ce.
module tb_paddle_pot_scheduler;

   logic            clk = 1'b0;
   logic            reset;
   logic            ce;
   logic            scan_start;
   logic            pair_sel;
   logic [3:0][7:0] pd_in;
   logic [3:0]      pd_valid;
   logic            pot_x;
   logic            pot_y;
   logic [7:0]      pot_val_x;
   logic [7:0]      pot_val_y;
   logic            busy;
   logic            settling;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          div8    = 1'b0;
   int          hold_err = 0;
   logic [19:0] snap;

   always #5 clk = ~clk;

   paddle_pot_scheduler #(
      .DISCHARGE_CYC(256),
      .SETTLE_SCANS (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .scan_start(scan_start),
      .pair_sel  (pair_sel),
      .pd_in     (pd_in),
      .pd_valid  (pd_valid),
      .pot_x     (pot_x),
      .pot_y     (pot_y),
      .pot_val_x (pot_val_x),
      .pot_val_y (pot_val_y),
      .busy      (busy),
      .settling  (settling)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] outs();
      return {pot_x, pot_y, pot_val_x, pot_val_y, busy, settling};
   endfunction

   // One ce tick; in div8 mode seven idle cycles precede it and outputs must hold.
   task automatic step();
      if (div8) begin
         ce = 1'b0;
         repeat (7) begin
            @(posedge clk); #1;
            if (outs() !== snap) hold_err++;
         end
      end
      ce = 1'b1;
      @(posedge clk); #1;
      snap = outs();
      if (div8) ce = 1'b0;
   endtask

   // Charge tick k lands on step 258+k; a clean scan ends after step 513.
   task automatic run_scan(input int poke_at, output int fx, output int fy, output int total);
      int n;
      fx = 999;
      fy = 999;
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      n = 1;
      while (busy && n < 2000) begin
         if (n == poke_at) begin
            scan_start = 1'b1;
            pd_in[2]   = 8'd120;
         end
         step();
         scan_start = 1'b0;
         n++;
         if (pot_x && fx == 999) fx = n - 258;
         if (pot_y && fy == 999) fy = n - 258;
      end
      total = n;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fx, fy, total;

      reset      = 1'b1;
      ce         = 1'b0;
      scan_start = 1'b0;
      pair_sel   = 1'b0;
      pd_in      = '0;
      pd_valid   = 4'hF;
      pd_in[0]   = 8'd100;
      pd_in[1]   = 8'd10;
      #12;
      check("rst_pot_x", pot_x, 0);
      check("rst_pot_y", pot_y, 0);
      check("rst_val_x", pot_val_x, 8'hFF);
      check("rst_val_y", pot_val_y, 8'hFF);
      check("rst_busy", busy, 0);
      check("rst_settling", settling, 0);
      @(negedge clk);
      reset = 1'b0;
      ce    = 1'b1;

      // basic scan
      run_scan(0, fx, fy, total);
      check("t1_fx", fx, 100);
      check("t1_fy", fy, 10);
      check("t1_total", total, 513);
      check("t1_val_x", pot_val_x, 100);
      check("t1_val_y", pot_val_y, 10);
      check("t1_busy", busy, 0);
      check("t1_pot_hold_idle", {pot_x, pot_y}, 2'b11);

      // invalid paddle and zero target
      pd_valid[1] = 1'b0;
      pd_in[0]    = 8'd0;
      run_scan(0, fx, fy, total);
      check("t2_fx", fx, 0);
      check("t2_fy", fy, 255);
      check("t2_val_x", pot_val_x, 0);
      check("t2_val_y", pot_val_y, 8'hFF);
      check("t2_total", total, 513);

      // pair switch with one settle scan
      pd_valid = 4'hF;
      pd_in[2] = 8'd50;
      pd_in[3] = 8'd200;
      pair_sel = 1'b1;
      @(posedge clk); #1;
      check("t3_settling", settling, 1);
      run_scan(0, fx, fy, total);
      check("t3a_fx", fx, 50);
      check("t3a_fy", fy, 200);
      check("t3a_val_x", pot_val_x, 0);
      check("t3a_val_y", pot_val_y, 8'hFF);
      check("t3a_settling", settling, 0);
      run_scan(0, fx, fy, total);
      check("t3b_val_x", pot_val_x, 50);
      check("t3b_val_y", pot_val_y, 200);

      // scan_start and pd_in change mid-CHARGE are ignored
      pd_in[2] = 8'd30;
      run_scan(300, fx, fy, total);
      check("t4_total", total, 513);
      check("t4_fx", fx, 30);
      check("t4_val_x", pot_val_x, 30);
      check("t4_busy", busy, 0);

      // async reset mid-CHARGE after pot_x rose
      pd_in[2]   = 8'd5;
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      repeat (266) step();
      check("t5_pre_pot_x", pot_x, 1);
      check("t5_pre_busy", busy, 1);
      pair_sel = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("t5_pot_x", pot_x, 0);
      check("t5_val_x", pot_val_x, 8'hFF);
      check("t5_busy", busy, 0);
      pd_in[0] = 8'd100;
      pd_in[1] = 8'd10;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("t5_settling", settling, 0);
      check("t5_idle", busy, 0);

      // ce at 1-in-8
      div8 = 1'b1;
      snap = outs();
      run_scan(0, fx, fy, total);
      check("t6_fx", fx, 100);
      check("t6_fy", fy, 10);
      check("t6_total", total, 513);
      check("t6_val_x", pot_val_x, 100);
      check("t6_val_y", pot_val_y, 10);
      check("t6_hold", hold_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
